timer_down: RTL and testbench
=============================

TIMER_DOWN -- requirements
Module: timer_down

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 pgt_1Hz  input  1  one-second enable from the upstream timer-control mux; one clk cycle wide per second.
REQ-005 load  input  1  level; captures d_in as the new count.
REQ-006 d_in  input  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}, 4 bits per digit, min_tens in [15:12].
REQ-007 start  input  1  level; begins or resumes the countdown.
REQ-008 stop  input  1  level; pauses the countdown.
REQ-009 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD count digits.
REQ-010 running  output  1  high while in RUNNING.
REQ-011 zero  output  1  high when all four digits are 0 (combinational from the digit registers).
REQ-012 done  output  1  registered one-cycle pulse when the countdown expires.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUNNING and PAUSED; running = (state == RUNNING).
REQ-014 In IDLE or PAUSED with load=1, the digits SHALL take d_in on the next edge, and the state SHALL become IDLE.
REQ-015 On load, d_in SHALL be sanitised per digit:
- any digit >9 -> 9;
- sec_tens >5 -> 5 (after the >9 rule).
REQ-016 In RUNNING, load SHALL be ignored.
REQ-017 In IDLE or PAUSED with start=1, load=0, stop=0 and zero=0, the next state SHALL be RUNNING.
REQ-018 start with zero=1 SHALL be ignored, and the state SHALL stay unchanged.
REQ-019 If load and start are both 1 in the same cycle, load SHALL win, start SHALL be ignored, and the state SHALL be IDLE.
REQ-020 In RUNNING with stop=1, the next state SHALL be PAUSED, the digits SHALL be held, and pgt_1Hz SHALL be ignored that cycle.
REQ-021 stop=1 SHALL override start=1 in every state.
REQ-022 In RUNNING with pgt_1Hz=1 and stop=0, the count SHALL decrement by one second on that edge (latency 1 clk).
REQ-023 Decrement rules:
- sec_ones 0 -> 9 and borrow, else -1;
- on borrow, sec_tens 0 -> 5 and borrow, else -1;
- on borrow, min_ones 0 -> 9 and borrow, else -1;
- on borrow, min_tens -1.
REQ-024 If the decrement produces 00:00, then on the same edge the state SHALL become IDLE and done SHALL be 1 for exactly that following cycle.
REQ-025 In RUNNING with pgt_1Hz=0, the digits SHALL hold.
REQ-026 Digits SHALL never leave BCD range, and sec_tens SHALL never exceed 5.
REQ-027 done SHALL be 0 in every cycle other than the one defined in REQ-024.
REQ-028 pgt_1Hz SHALL have no effect outside RUNNING.

Reset
REQ-029 While reset=1, regardless of clk:
- all digits SHALL be 0;
- the state SHALL be IDLE;
- running SHALL be 0, done SHALL be 0 and zero SHALL be 1.
REQ-030 reset asserted mid-countdown SHALL abort it without a done pulse.
REQ-031 After reset deasserts, operation SHALL resume on the next rising clk edge.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Load 16'h0105, start, 6 pgt_1Hz pulses -> 01:04, 01:03, 01:02, 01:01, 01:00, 00:59; running=1 throughout.
- Load 16'h0002, start, 2 pulses -> 00:01, then 00:00 with done=1 for one cycle, running=0, zero=1; a third pulse leaves 00:00 and done=0.
- Load 16'hFA7C -> digits read 99:59. Load 16'h1000, start, 1 pulse -> 09:59 (full borrow chain).
- Running at 00:30, assert stop together with pgt_1Hz -> PAUSED, 00:30 held. Then start -> RUNNING, and the next pulse gives 00:29.
- Load=1 and start=1 simultaneously with d_in=16'h0010 -> 00:10 and IDLE. Start with 00:00 loaded -> stays IDLE, done=0. Load during RUNNING -> ignored.
- Assert reset asynchronously between clk edges while running at 00:45 -> digits 00:00 immediately, running=0, and no done pulse ever issued.

Source files
------------

// File: rtl/timer_down.sv
// timer_down: BCD mm:ss countdown timer with load, start/stop control and a
// one-cycle done pulse. The count advances one second per pgt_1Hz enable
// while RUNNING, and the timer returns to IDLE when the count reaches 00:00.
module timer_down (
  input  logic        clk,
  input  logic        reset,
  input  logic        pgt_1Hz,
  input  logic        load,
  input  logic [15:0] d_in,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        zero,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] dec_s;
  logic        dec_zero_s;

  // Limit a single digit to the BCD range.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    if (d > 4'd9) begin
      return 4'd9;
    end else begin
      return d;
    end
  endfunction

  // Force a raw preset into a legal mm:ss value; seconds tens tops out at 5.
  function automatic logic [15:0] sanitise(input logic [15:0] v);
    logic [3:0] st;
    st = clamp9(v[7:4]);
    if (st > 4'd5) begin
      st = 4'd5;
    end else begin
      st = st;
    end
    return {clamp9(v[15:12]), clamp9(v[11:8]), st, clamp9(v[3:0])};
  endfunction

  // Subtract one second from a legal mm:ss value using a digit borrow chain.
  // Never applied to 00:00, since a zero count cannot be running.
  function automatic logic [15:0] dec_one(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign dec_s      = dec_one(cnt_q);
  assign dec_zero_s = (dec_s == 16'h0000);

  // Next-state, next-count and done-pulse decision for the control FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, PAUSED: begin
        if (load) begin
          // load wins over start and always lands in IDLE
          cnt_d   = sanitise(d_in);
          state_d = IDLE;
        end else if (start && !stop && !zero) begin
          state_d = RUNNING;
        end else begin
          state_d = state_q;
        end
      end
      RUNNING: begin
        if (stop) begin
          // pause holds the digits even if a 1 Hz tick arrives this cycle
          state_d = PAUSED;
        end else if (pgt_1Hz) begin
          cnt_d = dec_s;
          if (dec_zero_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUNNING;
          end
        end else begin
          state_d = RUNNING;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'h0000;
      end
    endcase
  end

  // State, count and done registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'h0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = cnt_q;
  assign running = (state_q == RUNNING);
  assign zero    = (cnt_q == 16'h0000);
  assign done    = done_q;

endmodule

// File: tb/tb_timer_down.sv
// Testbench for timer_down: directed scenarios followed by random stimulus,
// checked against a seconds-based reference model through a scoreboard queue.
module tb_timer_down;

  logic        clk;
  logic        reset;
  logic        pgt_1Hz;
  logic        load;
  logic [15:0] d_in;
  logic        start;
  logic        stop;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        running;
  logic        zero;
  logic        done;

  timer_down dut (
    .clk      (clk),
    .reset    (reset),
    .pgt_1Hz  (pgt_1Hz),
    .load     (load),
    .d_in     (d_in),
    .start    (start),
    .stop     (stop),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .zero     (zero),
    .done     (done)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic        run;
    logic        zro;
    logic        dn;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: remaining time in plain seconds plus a mode flag
  int m_secs = 0;
  int m_mode = 0;   // 0 idle, 1 running, 2 paused

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic int dig(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    logic [15:0] r;
    m  = s / 60;
    ss = s % 60;
    r  = {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    return r;
  endfunction

  // apply one cycle of stimulus, advance the model, queue the expected outputs
  task automatic step(input logic ld, input logic [15:0] din, input logic st,
                      input logic sp, input logic pgt);
    exp_t e;
    int   m, s;
    bit   dn;
    load = ld; d_in = din; start = st; stop = sp; pgt_1Hz = pgt;
    dn = 1'b0;
    if (m_mode != 1) begin
      if (ld) begin
        m = dig(din[15:12]) * 10 + dig(din[11:8]);
        s = dig(din[7:4]);
        if (s > 5) s = 5;
        m_secs = m * 60 + s * 10 + dig(din[3:0]);
        m_mode = 0;
      end else if (st && !sp && m_secs != 0) begin
        m_mode = 1;
      end
    end else begin
      if (sp) begin
        m_mode = 2;
      end else if (pgt) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = 0;
          dn = 1'b1;
        end
      end
    end
    e.digits = to_bcd(m_secs);
    e.run    = (m_mode == 1);
    e.zro    = (m_secs == 0);
    e.dn     = dn;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: compare DUT outputs with the oldest queued expectation after each edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("digits",  {min_tens, min_ones, sec_tens, sec_ones}, mon_e.digits);
      chk("running", {15'd0, running}, {15'd0, mon_e.run});
      chk("zero",    {15'd0, zero},    {15'd0, mon_e.zro});
      chk("done",    {15'd0, done},    {15'd0, mon_e.dn});
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_digits"},  {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    chk({tag, "_running"}, {15'd0, running}, 16'd0);
    chk({tag, "_zero"},    {15'd0, zero},    16'd1);
    chk({tag, "_done"},    {15'd0, done},    16'd0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; d_in = 16'h0000; start = 1'b0; stop = 1'b0; pgt_1Hz = 1'b0;
    #2;
    chk_reset_state("por");
    @(negedge clk);
    reset = 1'b0;
    idle_cyc();

    // 01:05 counting through a minute boundary
    step(1'b1, 16'h0105, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      idle_cyc();
    end

    // expiry with done pulse, then an extra tick has no effect
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle_cyc();

    // sanitising preset and the full borrow chain
    step(1'b1, 16'hFA7C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // stop together with a tick holds 00:30, then resume
    step(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // load while running is ignored; stop then load+start lands in IDLE
    step(1'b1, 16'h0555, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // asynchronous reset while running at 00:45
    step(1'b1, 16'h0045, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    m_secs = 0;
    m_mode = 0;
    #1;
    chk_reset_state("async");
    @(posedge clk);
    #1;
    chk_reset_state("hold");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    end

    // random phase
    for (int i = 0; i < 600; i++) begin
      logic        r_ld, r_st, r_sp, r_pgt;
      logic [15:0] r_din;
      r_ld  = ($urandom_range(0, 99) < 8);
      r_st  = ($urandom_range(0, 99) < 30);
      r_sp  = ($urandom_range(0, 99) < 8);
      r_pgt = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 3) == 0) begin
        r_din = 16'($urandom);
      end else begin
        r_din = {8'h00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      end
      step(r_ld, r_din, r_st, r_sp, r_pgt);
    end

    idle_cyc();
    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
